// File: rtl/decode_stage_pipe.sv
// ID stage: register file, load-use/writeback hazard detection and the ID/EX register (1-cycle D->E latency;
// hold_i freezes E, stall_fd holds F/D and inserts a bubble). Optional DECODE_WB_BYPASS_EN: same-cycle writeback write-through.
module decode_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int CTRL_W   = 8,
  parameter int LOAD_BIT = 0,
  localparam int AW      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_d,
  input  logic              valid_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pcplus4_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic              valid_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pcplus4_e,
  output logic [AW-1:0]     rs1_e,
  output logic [AW-1:0]     rs2_e,
  output logic [AW-1:0]     rd_e,
  output logic              stall_fd,
  output logic              load_use
);

  logic [XLEN-1:0] regFile [NREG];
  logic [AW-1:0]   rs1D, rs2D, rdD;
  logic [XLEN-1:0] rd1D, rd2D;
  logic            wbConflict;
  logic            unusedInstrBits;

  assign rs1D = instr_d[15 +: AW];
  assign rs2D = instr_d[20 +: AW];
  assign rdD  = instr_d[7 +: AW];
  // Opcode/funct bits are decoded upstream; only the index fields matter here.
  assign unusedInstrBits = ^instr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regFile[i] <= '0;
    end else if (wb_we && (wb_rd != '0)) begin
      regFile[wb_rd] <= wb_data;
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  assign rd1D = (rs1D == '0) ? '0 : ((wb_we && (wb_rd == rs1D)) ? wb_data : regFile[rs1D]);
  assign rd2D = (rs2D == '0) ? '0 : ((wb_we && (wb_rd == rs2D)) ? wb_data : regFile[rs2D]);
  assign wbConflict = 1'b0;
`else
  assign rd1D = (rs1D == '0) ? '0 : regFile[rs1D];
  assign rd2D = (rs2D == '0) ? '0 : regFile[rs2D];
  // Without write-through, stall one cycle so the reader sees the committed value.
  assign wbConflict = valid_d & wb_we & (wb_rd != '0) & ((wb_rd == rs1D) | (wb_rd == rs2D));
`endif

  // rs2 compared unconditionally: conservative for instructions without an rs2 field.
  assign load_use = valid_e & ctrl_e[LOAD_BIT] & (rd_e != '0) & valid_d &
                    ((rd_e == rs1D) | (rd_e == rs2D));
  assign stall_fd = (load_use | wbConflict) & ~flush_i & ~hold_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_e   <= 1'b0;
      ctrl_e    <= '0;
      rd1_e     <= '0;
      rd2_e     <= '0;
      imm_e     <= '0;
      pc_e      <= '0;
      pcplus4_e <= '0;
      rs1_e     <= '0;
      rs2_e     <= '0;
      rd_e      <= '0;
    end else begin
      // Data fields load unless held; flush overrides hold.
      if (flush_i || !hold_i) begin
        rd1_e     <= rd1D;
        rd2_e     <= rd2D;
        imm_e     <= imm_d;
        pc_e      <= pc_d;
        pcplus4_e <= pcplus4_d;
        rs1_e     <= rs1D;
        rs2_e     <= rs2D;
        rd_e      <= rdD;
      end
      if (flush_i || stall_fd) begin
        valid_e <= 1'b0;
        ctrl_e  <= '0;
      end else if (!hold_i) begin
        valid_e <= valid_d;
        ctrl_e  <= valid_d ? ctrl_d : '0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: reset, writeback/x0, load-use, flush, hold and WB collision.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d;
  logic        valid_d;
  logic [31:0] pc_d, pcplus4_d, imm_d, wb_data;
  logic [7:0]  ctrl_d;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic        hold_i, flush_i;
  logic        valid_e, stall_fd, load_use;
  logic [7:0]  ctrl_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pcplus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;

  int errCount = 0;
  int checkCount = 0;

  decode_stage_pipe dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d),
    .pc_d(pc_d), .pcplus4_d(pcplus4_d), .ctrl_d(ctrl_d), .imm_d(imm_d),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .hold_i(hold_i), .flush_i(flush_i),
    .valid_e(valid_e), .ctrl_e(ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_e(imm_e), .pc_e(pc_e), .pcplus4_e(pcplus4_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .stall_fd(stall_fd), .load_use(load_use)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkInstr(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setD(input logic v, input logic [31:0] ins, input logic [7:0] c,
                      input logic [31:0] pc, input logic [31:0] imm);
    valid_d   = v;
    instr_d   = ins;
    ctrl_d    = c;
    pc_d      = pc;
    pcplus4_d = pc + 32'd4;
    imm_d     = imm;
  endtask

  task automatic setWb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    wb_we   = we;
    wb_rd   = rd;
    wb_data = data;
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b0;
    hold_i = 1'b0;
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setD(1'($urandom), $urandom, 8'($urandom), $urandom, $urandom);
      setWb(1'($urandom), 5'($urandom), $urandom);
      hold_i  = 1'($urandom);
      flush_i = 1'($urandom);
      step();
    end
    setD(1'b0, 32'h0, 8'h0, 32'h0, 32'h0);
    setWb(1'b0, 5'd0, 32'h0);
    hold_i = 1'b0;
    flush_i = 1'b0;
    rst = 1'b1;
    #1;
    checkEq("rst_valid_e", 64'(valid_e), 64'd0);
    checkEq("rst_ctrl_e", 64'(ctrl_e), 64'd0);
    checkEq("rst_ops", {rd1_e, rd2_e}, 64'd0);
    checkEq("rst_pcs", {pc_e, pcplus4_e}, 64'd0);
    checkEq("rst_imm_idx", {imm_e, 17'd0, rs1_e, rs2_e, rd_e}, 64'd0);
    checkEq("rst_stall_fd", 64'(stall_fd), 64'd0);
    checkEq("rst_load_use", 64'(load_use), 64'd0);

    // Every register reads zero after reset
    for (int i = 0; i < 32; i++) begin
      setD(1'b1, mkInstr(5'd1, 5'(i), 5'(31 - i)), 8'h00, 32'h0, 32'h0);
      step();
      checkEq($sformatf("zero_reg_%0d", i), {rd1_e, rd2_e}, 64'd0);
    end

    // Writeback x5, then read it
    setD(1'b0, 32'h0, 8'h0, 32'h0, 32'h0);
    setWb(1'b1, 5'd5, 32'h1234_5678);
    step();
    setWb(1'b0, 5'd0, 32'h0);
    setD(1'b1, mkInstr(5'd2, 5'd5, 5'd0), 8'h10, 32'h100, 32'h44);
    #1;
    checkEq("wb5_no_stall", 64'(stall_fd), 64'd0);
    step();
    checkEq("wb5_valid_e", 64'(valid_e), 64'd1);
    checkEq("wb5_rd1_e", 64'(rd1_e), 64'h1234_5678);
    checkEq("wb5_rd2_e", 64'(rd2_e), 64'd0);
    checkEq("wb5_ctrl_e", 64'(ctrl_e), 64'h10);
    checkEq("wb5_pcs", {pc_e, pcplus4_e}, {32'h100, 32'h104});
    checkEq("wb5_imm_e", 64'(imm_e), 64'h44);
    checkEq("wb5_idx", {49'd0, rs1_e, rs2_e, rd_e}, {49'd0, 5'd5, 5'd0, 5'd2});

    // Write to x0 is discarded and raises no conflict
    setWb(1'b1, 5'd0, 32'hFFFF_FFFF);
    setD(1'b1, mkInstr(5'd3, 5'd0, 5'd0), 8'h10, 32'h110, 32'h0);
    #1;
    checkEq("x0_wb_no_stall", 64'(stall_fd), 64'd0);
    step();
    checkEq("x0_same_cycle_rd1", 64'(rd1_e), 64'd0);
    setWb(1'b0, 5'd0, 32'h0);
    step();
    checkEq("x0_after_wb_rd1", 64'(rd1_e), 64'd0);
    checkEq("x0_after_wb_valid", 64'(valid_e), 64'd1);

    // Load-use on x7
    setD(1'b0, 32'h0, 8'h0, 32'h0, 32'h0);
    setWb(1'b1, 5'd7, 32'h0000_0077);
    step();
    setWb(1'b0, 5'd0, 32'h0);
    setD(1'b1, mkInstr(5'd7, 5'd0, 5'd0), 8'h01, 32'h200, 32'h0);
    #1;
    checkEq("ld_issue_no_hazard", {62'd0, load_use, stall_fd}, 64'd0);
    step();
    checkEq("ld_in_e", {55'd0, valid_e, ctrl_e}, {55'd0, 1'b1, 8'h01});
    setD(1'b1, mkInstr(5'd8, 5'd7, 5'd0), 8'h10, 32'h204, 32'h0);
    setWb(1'b1, 5'd7, 32'h0000_BEEF);
    #1;
    checkEq("lu_load_use", 64'(load_use), 64'd1);
    checkEq("lu_stall_fd", 64'(stall_fd), 64'd1);
    step();
    setWb(1'b0, 5'd0, 32'h0);
    #1;
    checkEq("lu_bubble", {55'd0, valid_e, ctrl_e}, 64'd0);
    checkEq("lu_cleared", {62'd0, load_use, stall_fd}, 64'd0);
    step();
    checkEq("lu_add_valid", 64'(valid_e), 64'd1);
    checkEq("lu_add_rd1", 64'(rd1_e), 64'h0000_BEEF);
    checkEq("lu_add_pc_rd", {pc_e, 27'd0, rd_e}, {32'h204, 27'd0, 5'd8});

    // Flush beats stall
    setD(1'b1, mkInstr(5'd9, 5'd0, 5'd0), 8'h01, 32'h220, 32'h0);
    step();
    setD(1'b1, mkInstr(5'd4, 5'd0, 5'd9), 8'h10, 32'h224, 32'h0);
    flush_i = 1'b1;
    #1;
    checkEq("fl_load_use_rs2", 64'(load_use), 64'd1);
    checkEq("fl_stall_forced0", 64'(stall_fd), 64'd0);
    step();
    flush_i = 1'b0;
    checkEq("fl_killed", {55'd0, valid_e, ctrl_e}, 64'd0);
    checkEq("fl_data_loaded", {pc_e, 27'd0, rs2_e}, {32'h224, 27'd0, 5'd9});

    // Hold for three cycles
    setD(1'b1, mkInstr(5'd10, 5'd5, 5'd7), 8'h22, 32'h300, 32'h55);
    step();
    setD(1'b1, mkInstr(5'd11, 5'd7, 5'd5), 8'h33, 32'h400, 32'h66);
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkEq($sformatf("hold_stall_%0d", i), 64'(stall_fd), 64'd0);
      step();
      checkEq($sformatf("hold_vc_%0d", i), {55'd0, valid_e, ctrl_e}, {55'd0, 1'b1, 8'h22});
      checkEq($sformatf("hold_ops_%0d", i), {rd1_e, rd2_e}, {32'h1234_5678, 32'h0000_BEEF});
      checkEq($sformatf("hold_pc_imm_%0d", i), {pc_e, imm_e}, {32'h300, 32'h55});
      checkEq($sformatf("hold_rd_%0d", i), 64'(rd_e), 64'd10);
    end
    hold_i = 1'b0;
    step();
    checkEq("unhold_vc", {55'd0, valid_e, ctrl_e}, {55'd0, 1'b1, 8'h33});
    checkEq("unhold_ops", {rd1_e, rd2_e}, {32'h0000_BEEF, 32'h1234_5678});
    checkEq("unhold_pc_imm", {pc_e, imm_e}, {32'h400, 32'h66});
    checkEq("unhold_pc4_rd", {pcplus4_e, 27'd0, rd_e}, {32'h404, 27'd0, 5'd11});

    // Flush with hold: flush wins
    setD(1'b1, mkInstr(5'd12, 5'd0, 5'd0), 8'h44, 32'h500, 32'h0);
    hold_i = 1'b1;
    flush_i = 1'b1;
    step();
    hold_i = 1'b0;
    flush_i = 1'b0;
    checkEq("flhold_killed", {55'd0, valid_e, ctrl_e}, 64'd0);
    checkEq("flhold_pc", 64'(pc_e), 64'h500);

    // Same-cycle writeback / decode collision on x3
    setD(1'b1, mkInstr(5'd12, 5'd3, 5'd0), 8'h10, 32'h600, 32'h0);
    setWb(1'b1, 5'd3, 32'hA5A5_A5A5);
`ifdef DECODE_WB_BYPASS_EN
    #1;
    checkEq("coll_no_stall", 64'(stall_fd), 64'd0);
    step();
    setWb(1'b0, 5'd0, 32'h0);
    checkEq("coll_valid", 64'(valid_e), 64'd1);
    checkEq("coll_rd1", 64'(rd1_e), 64'hA5A5_A5A5);
`else
    #1;
    checkEq("coll_stall", 64'(stall_fd), 64'd1);
    step();
    setWb(1'b0, 5'd0, 32'h0);
    #1;
    checkEq("coll_bubble", 64'(valid_e), 64'd0);
    checkEq("coll_stall_done", 64'(stall_fd), 64'd0);
    step();
    checkEq("coll_valid", 64'(valid_e), 64'd1);
    checkEq("coll_rd1", 64'(rd1_e), 64'hA5A5_A5A5);
`endif

    // Load to x0 never causes a hazard
    setD(1'b1, mkInstr(5'd0, 5'd0, 5'd0), 8'h01, 32'h700, 32'h0);
    step();
    setD(1'b1, mkInstr(5'd13, 5'd0, 5'd0), 8'h10, 32'h704, 32'h0);
    #1;
    checkEq("x0_load_no_hazard", {62'd0, load_use, stall_fd}, 64'd0);
    step();
    setD(1'b0, 32'h0, 8'h0, 32'h0, 32'h0);
    checkEq("x0_load_next_valid", 64'(valid_e), 64'd1);
    step();
    checkEq("idle_ctrl_zero", {55'd0, valid_e, ctrl_e}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
